// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } imem_state_t;

  localparam int          IMEM_DEFAULT_LATENCY  = 4;
  localparam logic [15:0] IMEM_RESET_FETCH_ADDR = 16'h0800;

endpackage

// File: rtl/imem_array.sv
// Word-wide program store: synchronous write, registered read on the same edge,
// read-before-write when both hit the same word. rdata is zero unless re was high.
module imem_array
  #(parameter int DEPTH_LOG2 = 12)
  (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [15:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [15:0]           rdata
  );

  logic [15:0] mem_q [2**DEPTH_LOG2];
  logic [15:0] rdata_q;

  // Storage is never cleared, so a program loaded before reset survives it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 16'h0000;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end else begin
      rdata_q <= 16'h0000;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with a side preload port.
// Optional misalignment checking is enabled with IMEM_ALIGN_CHECK_EN.
module imem_responder
  import imem_pkg::*;
  #(
    parameter int LATENCY    = IMEM_DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = 12
  )
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic [15:0] addr,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic [1:0]  dbg_state
  );

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  imem_state_t           state_q;
  logic [3:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  done_q;
  logic                  stall_q;
  logic                  err_q;
  logic                  accept;
  logic                  read_fire;
  logic                  misaligned;
  logic                  load_ok;

  assign accept    = (state_q == ST_IDLE || state_q == ST_DONE) && rd;
  assign read_fire = (state_q == ST_BUSY) && (cnt_q == 4'd0) && !rst;

`ifdef IMEM_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= addr[0];
    end
  end

  assign misaligned = mis_q;
  assign load_ok    = !load_addr[0];
`else
  assign misaligned = 1'b0;
  assign load_ok    = 1'b1;
`endif

  // Handshake: rd is only looked at in IDLE/DONE; stall high means rd is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= IMEM_RESET_FETCH_ADDR[DEPTH_LOG2:1];
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (rd) begin
            idx_q   <= addr[DEPTH_LOG2:1];
            cnt_q   <= CNT_LOAD;
            stall_q <= 1'b1;
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            done_q  <= 1'b1;
            stall_q <= 1'b0;
            err_q   <= misaligned;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (load_en && load_ok),
    .waddr (load_addr[DEPTH_LOG2:1]),
    .wdata (load_data),
    .re    (read_fire && !misaligned),
    .raddr (idx_q),
    .rdata (data_out)
  );

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr, load_addr};

  assign done      = done_q;
  assign stall     = stall_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the fetch side of the pipeline. It accepts a 16-bit byte address from the PC/fetch stage with a read strobe and holds `stall` high for a fixed access latency. It then returns the 16-bit instruction word with a one-cycle `done` pulse. A side load port preloads the program image before and during execution; the first fetch after reset targets 16'h0800.

## Interface
- `LATENCY`, default 4: access latency in cycles; legal range 1–15.
- `DEPTH_LOG2`, default 12: log2 of the number of 16-bit words stored.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rd`  in  1  read request; sampled only when the block is able to accept.
- `addr`  in  16  byte address of the instruction.
- `load_en`  in  1  write strobe for preload.
- `load_addr`  in  16  byte address for preload.
- `load_data`  in  16  word to store.
- `data_out`  out  16  instruction word; valid only while `done` = 1, otherwise 16'h0000.
- `done`  out  1  one-cycle completion pulse.
- `stall`  out  1  high while a request is in flight.
- `err`  out  1  misaligned-address flag; see Configuration.

## Operation
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE. Reset enters IDLE.
- Reset values: `data_out` = 0, `done` = 0, `stall` = 0, `err` = 0, counter = 0. The storage array is not cleared.
- **Accepting a request:** `rd` is accepted in IDLE or DONE.
  - On the accepting edge, latch `addr` and load the counter with LATENCY-1.
  - Go to BUSY with `stall` = 1.
- **BUSY:**
  - If the counter is 0, the next edge reads the array at the latched address, registers the word on `data_out`, sets `done` = 1 and `stall` = 0, and goes to DONE.
  - Otherwise the counter decrements.
  - `rd` is ignored in BUSY. No queueing; the requester must hold off while `stall` = 1.
- **DONE:** lasts one cycle.
  - With `rd` = 1: accept back-to-back (to BUSY).
  - Otherwise go to IDLE, with `done` = 0 and `data_out` = 0.
- **Addressing:**
  - Word index = `addr[DEPTH_LOG2:1]`.
  - `addr[0]` and the bits above DEPTH_LOG2 are ignored, so out-of-range addresses wrap.
  - 16'h0800 maps to word 16'h0400.
- **Load port:**
  - `load_en` writes `load_data` at word index `load_addr[DEPTH_LOG2:1]` on the edge, in any FSM state.
  - A load completed on an earlier edge of the BUSY window is visible in the returned word.
  - A load on the same edge as the read and to the same word returns the old value (read-before-write).
- `rst` asserted mid-request aborts it: back to IDLE, no `done` pulse.

## Timing
- Accept edge k: `stall` = 1 in the cycle after edge k.
- `done` and valid `data_out` appear in the cycle after edge k+LATENCY, for exactly one cycle. `stall` is 0 in that cycle.
- With LATENCY = 1: `stall` is high for one cycle, then `done`.
- Back-to-back throughput: one word per LATENCY+1 cycles.
- `err` is registered alongside `done` and is valid only in the `done` cycle.

## Configuration
- Macro: `IMEM_ALIGN_CHECK_EN`.
- **Defined:**
  - If the latched `addr[0]` = 1, `err` = 1 in the `done` cycle.
  - `data_out` = 16'h0000 in that cycle, and the timing is unchanged.
  - Loads with `load_addr[0]` = 1 are dropped.
- **Undefined:**
  - `err` is tied to 0.
  - `addr[0]` and `load_addr[0]` are ignored.

## Structure
- Package `imem_pkg` holds:
  - the FSM state enum (IDLE, BUSY, DONE);
  - the default LATENCY;
  - the reset fetch address constant 16'h0800.
- Sub-module `imem_array`:
  - ports: synchronous write, read on the clock edge, read-before-write on collision;
  - parameterised by DEPTH_LOG2;
  - it holds the storage, and the FSM and counter stay in `imem_responder`.

## Test plan
- **Single read:** preload word 16'h0400 with 16'hC0DE, reset, then pulse `rd` with `addr` = 16'h0800. Expect `stall` high for 4 cycles, then `done` = 1 with `data_out` = 16'hC0DE for one cycle, then IDLE with outputs zero.
- **Back-to-back:** hold `rd` through the `done` cycle with new `addr` 16'h0802. Expect the second `done` exactly 5 cycles after the first, returning the preloaded 16'h1234.
- **Load collisions:**
  - A load to the in-flight word 2 cycles before `done` returns the new value.
  - A load on the `done`-producing edge returns the old value.
- **Reset mid-request:** assert `rst` 2 cycles after accept. Expect no `done` ever, all outputs 0, and the next request to behave normally.
- **Wrap:** with DEPTH_LOG2 = 12, reading `addr` = 16'h2800 returns the same word as 16'h0800.
- **Misalignment:** read `addr` = 16'h0801.
  - With `IMEM_ALIGN_CHECK_EN` defined: `err` = 1 and `data_out` = 0 in the `done` cycle.
  - Without it: `err` = 0 and the word at 16'h0800 is returned.
